// File: rtl/ss_readback_decoder.sv
// ss_readback_decoder
//
// Reads a time-multiplexed, active-low seven-segment bus back into hex nibbles.
// Each (seg_in, digit_sel) pair is registered, then must stay identical for
// STABLE_CYCLES consecutive samples before it is committed to its digit slot.
// Patterns that are neither a hex glyph nor blank raise err / err_sticky.
//
// Optional feature: define SS_DECODE_ERR_COUNT_EN to build the saturating
// 8-bit illegal-pattern counter on err_count. When undefined, err_count is
// tied to zero.

module ss_readback_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd_valid,
    output logic [2:0]              upd_digit,
    output logic                    upd_blank,
    output logic                    err,
    output logic                    err_sticky,
    output logic [7:0]              err_count
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    // Input sample pair and the pair from the previous cycle
    logic [6:0]            seg_smp_reg;
    logic [NUM_DIGITS-1:0] sel_smp_reg;
    logic [6:0]            seg_prev_reg;
    logic [NUM_DIGITS-1:0] sel_prev_reg;

    // Settle tracking
    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [7:0] stable_cnt_reg;
    logic [7:0] stable_cnt_next;

    // Decoded view of the current sample
    logic       glyph_hex;
    logic       glyph_blank;
    logic [3:0] glyph_nib;
    logic       sel_onehot;
    logic [3:0] sel_ones;
    logic [2:0] sel_idx;
    logic       sample_same;

    // Commit strobes
    logic commit;
    logic commit_hex;
    logic commit_blank;
    logic commit_bad;

    // Registered status outputs
    logic       upd_valid_reg;
    logic [2:0] upd_digit_reg;
    logic       upd_blank_reg;
    logic       err_reg;
    logic       err_sticky_reg;

    // Register the bus and keep one cycle of history for the stability compare
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_smp_reg  <= '0;
            sel_smp_reg  <= '0;
            seg_prev_reg <= '0;
            sel_prev_reg <= '0;
        end else begin
            seg_smp_reg  <= seg_in;
            sel_smp_reg  <= digit_sel;
            seg_prev_reg <= seg_smp_reg;
            sel_prev_reg <= sel_smp_reg;
        end
    end

    // Glyph lookup on the sampled segments (pattern shown as g..a, active-low)
    always_comb begin
        glyph_hex   = 1'b1;
        glyph_blank = 1'b0;
        glyph_nib   = 4'h0;
        case (seg_smp_reg)
            7'h40:   glyph_nib = 4'h0;
            7'h79:   glyph_nib = 4'h1;
            7'h24:   glyph_nib = 4'h2;
            7'h30:   glyph_nib = 4'h3;
            7'h19:   glyph_nib = 4'h4;
            7'h12:   glyph_nib = 4'h5;
            7'h02:   glyph_nib = 4'h6;
            7'h78:   glyph_nib = 4'h7;
            7'h00:   glyph_nib = 4'h8;
            7'h10:   glyph_nib = 4'h9;
            7'h08:   glyph_nib = 4'hA;
            7'h03:   glyph_nib = 4'hB;
            7'h46:   glyph_nib = 4'hC;
            7'h21:   glyph_nib = 4'hD;
            7'h06:   glyph_nib = 4'hE;
            7'h0E:   glyph_nib = 4'hF;
            7'h7F: begin
                glyph_hex   = 1'b0;
                glyph_blank = 1'b1;
            end
            default: glyph_hex = 1'b0;
        endcase
    end

    // One-hot check and digit index of the sampled select
    always_comb begin
        sel_ones = 4'd0;
        sel_idx  = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_smp_reg[i]) begin
                sel_ones = sel_ones + 4'd1;
                sel_idx  = 3'(i);
            end
        end
        sel_onehot  = (sel_ones == 4'd1);
        sample_same = (seg_smp_reg == seg_prev_reg) && (sel_smp_reg == sel_prev_reg);
    end

    // Settle FSM: count identical one-hot samples, commit once at the limit
    always_comb begin
        state_next      = state_reg;
        stable_cnt_next = stable_cnt_reg;
        commit          = 1'b0;
        if (!sel_onehot) begin
            // Blanking gap or overlapping selects: nothing to track
            state_next      = ST_IDLE;
            stable_cnt_next = 8'd0;
        end else if (state_reg == ST_DONE) begin
            // Already committed this pair; only a new pair restarts tracking
            if (!sample_same) begin
                state_next      = ST_TRACK;
                stable_cnt_next = 8'd1;
            end
        end else begin
            if ((state_reg == ST_TRACK) && sample_same) begin
                stable_cnt_next = (stable_cnt_reg >= STABLE_LIMIT) ? STABLE_LIMIT
                                                                   : stable_cnt_reg + 8'd1;
            end else begin
                stable_cnt_next = 8'd1;
            end
            state_next = ST_TRACK;
            if (stable_cnt_next == STABLE_LIMIT) begin
                commit     = 1'b1;
                state_next = ST_DONE;
            end
        end
    end

    assign commit_hex   = commit && glyph_hex;
    assign commit_blank = commit && glyph_blank;
    assign commit_bad   = commit && !glyph_hex && !glyph_blank;

    // FSM state and settle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            stable_cnt_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            stable_cnt_reg <= stable_cnt_next;
        end
    end

    // Per-digit result slots: hex writes the nibble, blank only drops valid
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [3:0] nib_reg;
            logic       vld_reg;

            // Update this slot when a commit targets it
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    nib_reg <= 4'h0;
                    vld_reg <= 1'b0;
                end else if (commit_hex && sel_smp_reg[gi]) begin
                    nib_reg <= glyph_nib;
                    vld_reg <= 1'b1;
                end else if (commit_blank && sel_smp_reg[gi]) begin
                    vld_reg <= 1'b0;
                end
            end

            assign value_out[4*gi +: 4] = nib_reg;
            assign digit_valid[gi]      = vld_reg;
        end
    endgenerate

    // Update pulse and the index/blank qualifiers of the latest legal commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upd_valid_reg <= 1'b0;
            upd_digit_reg <= 3'd0;
            upd_blank_reg <= 1'b0;
        end else begin
            upd_valid_reg <= commit_hex || commit_blank;
            if (commit_hex || commit_blank) begin
                upd_digit_reg <= sel_idx;
                upd_blank_reg <= commit_blank;
            end
        end
    end

    // Illegal-pattern pulse and sticky flag; a same-edge commit beats err_clr
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_reg        <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            err_reg <= commit_bad;
            if (commit_bad) begin
                err_sticky_reg <= 1'b1;
            end else if (err_clr) begin
                err_sticky_reg <= 1'b0;
            end
        end
    end

`ifdef SS_DECODE_ERR_COUNT_EN
    logic [7:0] err_count_reg;

    // Saturating illegal-commit counter; a clear and a commit together leave 1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count_reg <= 8'd0;
        end else if (commit_bad) begin
            if (err_clr) begin
                err_count_reg <= 8'd1;
            end else if (err_count_reg != 8'hFF) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end else if (err_clr) begin
            err_count_reg <= 8'd0;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'd0;
`endif

    assign upd_valid  = upd_valid_reg;
    assign upd_digit  = upd_digit_reg;
    assign upd_blank  = upd_blank_reg;
    assign err        = err_reg;
    assign err_sticky = err_sticky_reg;

endmodule
